// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 link-layer types and constants
// Also used by the downstream scan-code decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam int         PS2_FRAME_BITS   = 11;
    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

    // PS/2 uses odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_glitch_filter.sv
// rtl/ps2_glitch_filter.sv - synchroniser plus run-length filter for one PS/2 line
// level_o only changes after FILTER_LEN identical synced samples; fall_o strobes on 1->0.
module ps2_glitch_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   fall_q, fall_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
        level_d = level_q;
        cnt_d   = '0;
        // Any sample agreeing with the current level restarts the run count.
        if (sync_q[SYNC_STAGES-1] != level_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        fall_d = level_q & ~level_d;
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_rx_deserializer.sv
// rtl/ps2_rx_deserializer.sv - receive-only PS/2 frame deserialiser
// Turns filtered PS2_CLK falls plus synced PS2_DAT into validated scan-code bytes.
module ps2_rx_deserializer
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] received_data,
    output logic       received_data_en,
    output logic       rx_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    ps2_state_e             state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [7:0]             rdata_q, rdata_d;
    logic                   en_q, en_d;
    logic                   err_q, err_d;
    logic [SYNC_STAGES-1:0] dat_sync_q;

    logic clk_level;
    logic fall;
    logic dat;
    logic timeout;
    logic stop_fall;

    ps2_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk_i  (CLOCK_50),
        .rst_ni (resetn),
        .raw_i  (PS2_CLK),
        .level_o(clk_level),
        .fall_o (fall)
    );

    assign dat       = dat_sync_q[SYNC_STAGES-1];
    // A fall in the same cycle as expiry wins: the bit is accepted instead.
    assign timeout   = !fall && (state_q != ST_IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign stop_fall = fall && (state_q == ST_STOP);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            rdata_q    <= '0;
            en_q       <= 1'b0;
            err_q      <= 1'b0;
            dat_sync_q <= '1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            rdata_q    <= rdata_d;
            en_q       <= en_d;
            err_q      <= err_d;
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], PS2_DAT};
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = (fall || state_q == ST_IDLE) ? '0 : tmo_q + 1'b1;
        if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = dat;
                    state_d = ST_STOP;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
        end
    end

    always_comb begin
        en_d    = stop_fall && odd_parity_ok(shift_q, par_q) && dat;
        err_d   = (stop_fall && !(odd_parity_ok(shift_q, par_q) && dat)) || timeout;
        rdata_d = en_d ? shift_q : rdata_q;
    end

    assign received_data    = rdata_q;
    assign received_data_en = en_q;
    assign rx_error         = err_q;

    logic unused_level;
    assign unused_level = clk_level;

endmodule

// File: tb/tb_ps2_rx_deserializer.sv
// tb/tb_ps2_rx_deserializer.sv - directed bench with frame-level reference model
module tb_ps2_rx_deserializer;

    localparam int HALF = 40;
    localparam int TMO  = 1000;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] rdata;
    logic       en;
    logic       err;

    always #5 clk = ~clk;

    ps2_rx_deserializer #(
        .SYNC_STAGES   (2),
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLOCK_50        (clk),
        .resetn          (resetn),
        .PS2_CLK         (ps2_clk),
        .PS2_DAT         (ps2_dat),
        .received_data   (rdata),
        .received_data_en(en),
        .rx_error        (err)
    );

    typedef struct {
        bit         is_err;
        bit         timed;
        logic [7:0] data;
    } ev_t;

    ev_t        expq[$];
    ev_t        ev;
    logic [7:0] exp_held = 8'h00;
    int         nvec = 0;
    int         nmis = 0;
    int         cyc = 0;
    int         fall_cyc = 0;
    int         lat;
    int         n_en = 0;
    int         n_err = 0;
    int         e0, r0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame as driven on the wire: bit0 start, bits 8:1 data LSB first, bit9 parity, bit10 stop.
    function automatic logic [10:0] mk(input logic [7:0] d, input bit bad_par);
        return {1'b1, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    function automatic void predict(input logic [10:0] f);
        bit ok;
        if (f[0] != 1'b0) return;
        ok = ($countones(f[9:1]) % 2 == 1) && f[10];
        expq.push_back('{is_err: !ok, timed: 1'b1, data: f[8:1]});
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            if (i == glitch_bit) begin
                tick(HALF / 2);
                ps2_clk = 1'b0;
                tick(3);
                ps2_clk = 1'b1;
                tick(HALF - HALF / 2 - 3);
            end else begin
                tick(HALF);
            end
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            tick(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [10:0] f, input int glitch_bit);
        predict(f);
        send_bits(f, 11, glitch_bit);
    endtask

    task automatic settle();
        tick(20);
        chk("pending_events", expq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!resetn) begin
            chk("reset_data", rdata, 8'h00);
            chk("reset_en", en, 1'b0);
            chk("reset_err", err, 1'b0);
            exp_held = 8'h00;
        end else begin
            chk("en_err_exclusive", en & err, 1'b0);
            if (en === 1'b1 || err === 1'b1) begin
                if (en === 1'b1) n_en++;
                if (err === 1'b1) n_err++;
                if (expq.size() == 0) begin
                    chk("unexpected_pulse", {en, err}, 2'b00);
                end else begin
                    ev = expq.pop_front();
                    chk("event_kind", err, ev.is_err);
                    if (!ev.is_err) begin
                        chk("event_data", rdata, ev.data);
                        exp_held = ev.data;
                    end
                    if (ev.timed) begin
                        lat = cyc - fall_cyc;
                        chk("event_latency", (lat >= 9 && lat <= 14), 1'b1);
                    end
                end
            end
            chk("held_data", rdata, exp_held);
        end
    end

    initial begin
        tick(5);
        chk("por_data", rdata, 8'h00);
        chk("por_en", en, 1'b0);
        resetn = 1'b1;
        tick(20);

        chk("model_frame_1C", mk(8'h1C, 1'b0), 11'h438);
        chk("model_frame_F0", mk(8'hF0, 1'b0), 11'h7E0);

        e0 = n_en; r0 = n_err;
        send_frame(mk(8'h1C, 1'b0), -1);
        settle();
        chk("t1_data", rdata, 8'h1C);
        chk("t1_en_count", n_en - e0, 1);
        chk("t1_err_count", n_err - r0, 0);

        e0 = n_en;
        send_frame(mk(8'hF0, 1'b0), -1);
        send_frame(mk(8'h1C, 1'b0), -1);
        settle();
        chk("t2_en_count", n_en - e0, 2);
        chk("t2_data", rdata, 8'h1C);

        e0 = n_en; r0 = n_err;
        send_frame(mk(8'h1C, 1'b1), -1);
        settle();
        chk("t3_err_count", n_err - r0, 1);
        chk("t3_en_count", n_en - e0, 0);
        chk("t3_data_kept", rdata, 8'h1C);

        e0 = n_en; r0 = n_err;
        expq.push_back('{is_err: 1'b1, timed: 1'b0, data: 8'h00});
        send_bits(mk(8'h29, 1'b0), 4, -1);
        tick(1100);
        chk("t4_timeout_err", n_err - r0, 1);
        chk("t4_timeout_no_en", n_en - e0, 0);
        send_frame(mk(8'h29, 1'b0), -1);
        settle();
        chk("t4_data", rdata, 8'h29);

        e0 = n_en; r0 = n_err;
        repeat (3) begin
            ps2_clk = 1'b0;
            tick(3);
            ps2_clk = 1'b1;
            tick(30);
        end
        send_frame(mk(8'h66, 1'b0), 4);
        settle();
        chk("t5_data", rdata, 8'h66);
        chk("t5_en_count", n_en - e0, 1);
        chk("t5_err_count", n_err - r0, 0);

        send_bits(mk(8'h45, 1'b0), 4, -1);
        resetn = 1'b0;
        tick(2);
        chk("t6_reset_data", rdata, 8'h00);
        chk("t6_reset_en", en, 1'b0);
        tick(3);
        resetn = 1'b1;
        e0 = n_en; r0 = n_err;
        tick(20);
        chk("t6_aborted_silent", (n_en - e0) + (n_err - r0), 0);
        send_frame(mk(8'h45, 1'b0), -1);
        settle();
        chk("t6_data", rdata, 8'h45);
        chk("t6_en_count", n_en - e0, 1);
        chk("t6_err_count", n_err - r0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
